// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: parses framed register read/write commands from a UART byte
// stream, executes them on a 16x8 register file and returns an acknowledge frame.
module uart_cmd_responder #(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       rx_err,
   input  logic       tx_busy,
   output logic [7:0] tx_data,
   output logic       tx_req,
   output logic [7:0] ctrl_out,
   input  logic [7:0] status_in,
   output logic       busy,
   output logic       frame_drop
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [3:0] {IDLE, CMD, ADDR, DATA, CSUM, EXEC, TX_HDR, TX_STAT, TX_DATA} state_t;
   typedef enum logic [1:0] {ISSUE, GUARD, WAIT} phase_t;
   state_t        state_q, state_d;
   phase_t        phase_q, phase_d;
   logic [7:0]    cmd_q, cmd_d, addr_q, addr_d, data_q, data_d;
   logic [7:0]    status_q, status_d, rdata_q, rdata_d;
   logic          err_q, err_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    regs_q [16];
   logic [7:0]    regs_d [16];
   logic          collect, in_tx, rd_ok, err_all;
   logic [7:0]    csum_exp;
   assign collect    = state_q inside {CMD, ADDR, DATA, CSUM};
   assign in_tx      = state_q inside {TX_HDR, TX_STAT, TX_DATA};
   assign rd_ok      = status_q == 8'h00 && cmd_q == 8'h02;
   assign err_all    = err_q | rx_err;
   assign csum_exp   = cmd_q ^ addr_q ^ (cmd_q == 8'h01 ? data_q : 8'h00);
   assign busy       = state_q != IDLE;
   assign ctrl_out   = regs_q[0];
   assign tx_req     = in_tx && phase_q == ISSUE && !tx_busy;
   assign tx_data    = state_q == TX_HDR ? 8'h5A : state_q == TX_STAT ? status_q :
                       state_q == TX_DATA ? rdata_q : 8'h00;
   // A byte arriving in the expiry cycle wins because expiry requires !rx_valid
   assign frame_drop = collect && !rx_valid && cnt_q == CW'(TIMEOUT_CYCLES - 1);
   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      cmd_d    = cmd_q;
      addr_d   = addr_q;
      data_d   = data_q;
      status_d = status_q;
      rdata_d  = rdata_q;
      regs_d   = regs_q;
      err_d    = err_q | (collect & rx_valid & rx_err);
      cnt_d    = collect ? (rx_valid ? '0 : cnt_q + CW'(1)) : '0;
      case (state_q)
         IDLE: if (rx_valid && rx_data == 8'hA5) begin
            state_d = CMD;
            err_d   = rx_err;
         end
         CMD: if (rx_valid) begin
            cmd_d   = rx_data;
            state_d = ADDR;
         end
         ADDR: if (rx_valid) begin
            addr_d  = rx_data;
            state_d = cmd_q == 8'h01 ? DATA : CSUM;
         end
         DATA: if (rx_valid) begin
            data_d  = rx_data;
            state_d = CSUM;
         end
         CSUM: if (rx_valid) begin
            status_d = err_all ? 8'h03 : rx_data != csum_exp ? 8'h01 :
                       !(cmd_q inside {8'h01, 8'h02}) ? 8'h02 :
                       (cmd_q == 8'h01 && addr_q[3:0] == 4'hF) ? 8'h04 : 8'h00;
            state_d  = EXEC;
         end
         EXEC: begin
            if (status_q == 8'h00 && cmd_q == 8'h01) regs_d[addr_q[3:0]] = data_q;
            rdata_d = addr_q[3:0] == 4'hF ? status_in : regs_q[addr_q[3:0]];
            phase_d = ISSUE;
            state_d = TX_HDR;
         end
         default: begin
            phase_d = phase_q == ISSUE ? (tx_busy ? ISSUE : GUARD) :
                      phase_q == GUARD ? WAIT : (tx_busy ? WAIT : ISSUE);
            if (phase_q == WAIT && !tx_busy)
               state_d = state_q == TX_HDR ? TX_STAT : (state_q == TX_STAT && rd_ok) ? TX_DATA : IDLE;
         end
      endcase
      if (frame_drop) state_d = IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         phase_q  <= ISSUE;
         cmd_q    <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         status_q <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
         regs_q   <= '{default: '0};
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         cmd_q    <= cmd_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         status_q <= status_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
         regs_q   <= regs_d;
      end
   end
endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb_uart_cmd_responder: scoreboard bench; frames push expected response bytes,
// a monitor pops them on each tx_req and checks the transmit handshake.
module tb_uart_cmd_responder;
   localparam int T = 40;
   logic       clk = 0, rst = 1;
   logic [7:0] rx_data = 0, status_in = 0;
   logic       rx_valid = 0, rx_err = 0, tx_busy = 0;
   logic [7:0] tx_data, ctrl_out;
   logic       tx_req, busy, frame_drop;
   int         vec = 0, errs = 0, drops = 0, bp_fixed = 0;
   logic [7:0] exp_q [$];
   logic [7:0] mregs [16];
   logic       outstanding = 0, guard = 0;
   logic [7:0] held = 0;

   uart_cmd_responder #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
      .tx_busy(tx_busy), .tx_data(tx_data), .tx_req(tx_req), .ctrl_out(ctrl_out),
      .status_in(status_in), .busy(busy), .frame_drop(frame_drop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      vec++;
      if (a !== e) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endtask

   // Transmitter model: busy for a while after each accepted request
   initial begin
      int n;
      forever begin
         @(negedge clk);
         if (tx_req && !rst) begin
            n = bp_fixed > 0 ? bp_fixed : int'($urandom_range(0, 4));
            @(posedge clk);
            #1;
            if (n > 0) begin
               tx_busy = 1;
               repeat (n) @(posedge clk);
               #1 tx_busy = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         outstanding = 0;
         guard = 0;
      end else begin
         if (frame_drop) drops++;
         if (tx_req) begin
            chk("req_while_pending", outstanding, 0);
            chk("tx_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("tx_byte", tx_data, exp_q.pop_front());
            held = tx_data;
            outstanding = 1;
            guard = 1;
         end else if (outstanding) begin
            if (guard || tx_busy) chk("tx_data_hold", tx_data, held);
            if (!guard && !tx_busy) outstanding = 0;
            guard = 0;
         end
      end
   end

   task automatic send(input logic [7:0] b, input logic e, input int gap);
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      rx_data = b;
      rx_err = e;
      rx_valid = 1;
      @(posedge clk);
      #1;
      rx_valid = 0;
      rx_err = 0;
   endtask

   task automatic frame(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] cs, input logic [4:0] e, input int gmax);
      logic [7:0] b [$];
      logic       anyerr;
      logic [7:0] st, good;
      b = {8'hA5, cmd, a};
      if (cmd == 8'h01) b.push_back(d);
      b.push_back(cs);
      anyerr = 0;
      for (int i = 0; i < b.size(); i++) anyerr |= e[i];
      good = cmd == 8'h01 ? 8'h01 ^ a ^ d : cmd ^ a;
      st = anyerr ? 8'h03 : cs != good ? 8'h01 : (cmd != 8'h01 && cmd != 8'h02) ? 8'h02 :
           (cmd == 8'h01 && a[3:0] == 4'hF) ? 8'h04 : 8'h00;
      exp_q.push_back(8'h5A);
      exp_q.push_back(st);
      if (st == 8'h00) begin
         if (cmd == 8'h01) mregs[a[3:0]] = d;
         else exp_q.push_back(a[3:0] == 4'hF ? status_in : mregs[a[3:0]]);
      end
      for (int i = 0; i < b.size(); i++) send(b[i], e[i], gmax > 0 ? int'($urandom_range(0, gmax)) : 0);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("reach_idle", busy, 0);
      @(posedge clk);
      #1;
      chk("resp_drained", exp_q.size(), 0);
      chk("ctrl_out", ctrl_out, mregs[0]);
   endtask

   initial begin
      int k;
      logic [7:0] c, a, d, g;
      mregs = '{default: 8'h00};
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_tx_req", tx_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ctrl", ctrl_out, 0);
      chk("rst_drop", frame_drop, 0);
      chk("rst_tx_data", tx_data, 0);
      @(posedge clk);
      #1;
      frame(8'h01, 8'h03, 8'h5C, 8'h5E, 0, 0); wait_idle();
      frame(8'h02, 8'h03, 8'h00, 8'h01, 0, 0); wait_idle();
      frame(8'h01, 8'h00, 8'h81, 8'h80, 0, 0);
      @(negedge clk);
      chk("ctrl_in_exec", ctrl_out, 8'h00);
      chk("busy_in_exec", busy, 1);
      @(negedge clk);
      chk("ctrl_after_exec", ctrl_out, 8'h81);
      @(posedge clk);
      #1;
      wait_idle();
      frame(8'h01, 8'h04, 8'h11, 8'h00, 0, 0); wait_idle();
      frame(8'h01, 8'h04, 8'h11, 8'h00, 5'b01000, 0); wait_idle();
      frame(8'h02, 8'h04, 8'h00, 8'h06, 0, 0); wait_idle();
      frame(8'h01, 8'h0F, 8'h22, 8'h2C, 0, 0); wait_idle();
      status_in = 8'hC3;
      frame(8'h02, 8'h0F, 8'h00, 8'h0D, 0, 0); wait_idle();
      frame(8'h07, 8'h02, 8'h00, 8'h05, 0, 0); wait_idle();
      // Timeout: partial frame abandoned, no response
      send(8'hA5, 0, 0);
      send(8'h01, 0, 0);
      k = 0;
      while (k < T + 10) begin
         @(negedge clk);
         k++;
         if (frame_drop) break;
      end
      chk("timeout_cycle", k, T);
      @(negedge clk);
      chk("busy_after_drop", busy, 0);
      @(posedge clk);
      #1;
      frame(8'h02, 8'h00, 8'h00, 8'h02, 0, 0); wait_idle();
      // Byte landing in the expiry cycle keeps the frame alive
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'h00);
      exp_q.push_back(mregs[3]);
      send(8'hA5, 0, 0);
      send(8'h02, 0, 0);
      send(8'h03, 0, T - 1);
      send(8'h01, 0, 0);
      wait_idle();
      // Backpressure with junk bytes during the response
      bp_fixed = 50;
      frame(8'h01, 8'h07, 8'h3C, 8'h3A, 0, 0);
      send(8'h00, 0, 3);
      send(8'hA5, 0, 3);
      wait_idle();
      frame(8'h02, 8'h07, 8'h00, 8'h05, 0, 0);
      send(8'h00, 0, 3);
      send(8'hA5, 0, 3);
      wait_idle();
      bp_fixed = 0;
      repeat (60) begin
         if ($urandom_range(0, 4) == 0) begin
            g = 8'($urandom);
            send(g == 8'hA5 ? 8'h00 : g, 0, int'($urandom_range(0, 2)));
         end
         k = int'($urandom_range(0, 5));
         c = k < 3 ? 8'h01 : k < 5 ? 8'h02 : 8'($urandom);
         a = 8'($urandom);
         d = 8'($urandom);
         g = c == 8'h01 ? 8'h01 ^ a ^ d : c ^ a;
         if ($urandom_range(0, 6) == 0) g ^= 8'($urandom_range(1, 255));
         status_in = 8'($urandom);
         frame(c, a, d, g, $urandom_range(0, 9) == 0 ? 5'(1 << $urandom_range(0, 4)) : 5'd0, 3);
         wait_idle();
      end
      chk("drop_count", drops, 1);
      chk("queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule

// File: doc/uart_cmd_responder.md
# uart_cmd_responder

Byte-level command responder that sits behind the UART core's receive/transmit byte ports. It parses framed register-access commands from the received byte stream and executes them against an internal 16 x 8 register file. It then returns an acknowledge frame through the transmitter's request/busy handshake. It is the target end of the host register-access link; the host is the initiator.

## Interface

Parameters:
- TIMEOUT_CYCLES, 100000, inter-byte timeout in clk cycles during frame collection. Minimum 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- rx_data  input  8  received byte; valid only while rx_valid is high.
- rx_valid  input  1  one-cycle strobe, one per received byte.
- rx_err  input  1  receiver error flag, sampled only when rx_valid is high.
- tx_busy  input  1  transmitter busy; a byte is accepted only while low.
- tx_data  output  8  byte to transmit; held stable from tx_req until tx_busy falls.
- tx_req  output  1  one-cycle transmit request.
- ctrl_out  output  8  live copy of register 0x0.
- status_in  input  8  read-only value returned for address 0xF.
- busy  output  1  high whenever the FSM is not in IDLE.
- frame_drop  output  1  one-cycle pulse when a partial frame is abandoned on timeout.

## Operation

- Write frame: A5, 01, addr, data, csum. csum = 01 ^ addr ^ data.
- Read frame: A5, 02, addr, csum. csum = 02 ^ addr.
- Any other command byte is treated as a read-length frame, with csum = cmd ^ addr.
- Only addr[3:0] is used; addr[7:4] is ignored but still enters the checksum.
- Registers 0x0–0xE are read/write. 0xF is read-only and reads status_in.
- Response: 5A, status, then a third byte only for a successful read (the register value).
- Status codes and priority, highest first:
  - 03: any byte in the frame had rx_err set.
  - 01: checksum mismatch.
  - 02: unknown command.
  - 04: write to 0xF.
  - 00: OK.
- A write is performed only with status 00.
- FSM states: IDLE, CMD, ADDR, DATA, CSUM, EXEC, TX_HDR, TX_STAT, TX_DATA.
- IDLE: on an rx_valid byte equal to A5 go to CMD. Any other byte is discarded and the FSM stays in IDLE.
- CMD: store cmd, go to ADDR.
- ADDR: store addr. For cmd 01 go to DATA, otherwise go to CSUM.
- DATA: store data, go to CSUM.
- CSUM: compare, compute status, go to EXEC.
- EXEC: one cycle. Performs the register write or latches the read value, then goes to TX_HDR.
- Each TX_* state has two phases:
  - Issue phase: when tx_busy is low, drive tx_data and pulse tx_req.
  - Wait phase: one guard cycle, then wait for tx_busy low.
  - Then advance to the next state.
- TX_STAT goes to TX_DATA on a successful read, otherwise to IDLE. TX_DATA goes to IDLE.
- rx_err is accumulated into a sticky frame flag. The flag is cleared when the A5 byte is accepted in IDLE.
- Bytes arriving during EXEC or any TX_* state are dropped and do not affect the FSM.
- Timeout:
  - A counter runs in CMD, ADDR, DATA and CSUM, and reloads on every rx_valid.
  - On reaching TIMEOUT_CYCLES with no byte, the FSM goes to IDLE and pulses frame_drop.
  - No response is sent.
- An A5 byte received mid-frame is treated as ordinary data. No resync occurs.

## Timing

- Reset values: tx_data 00, tx_req 0, ctrl_out 00, all registers 00, busy 0, frame_drop 0, FSM in IDLE.
- Reset asserted mid-frame or mid-response aborts immediately. A tx_req already issued is not retracted.
- Checksum byte strobed in cycle N:
  - EXEC in cycle N+1.
  - ctrl_out and the register write update at the end of N+1.
  - First tx_req in cycle N+2 if tx_busy is low, otherwise in the first cycle after tx_busy falls.
- After each tx_req, tx_busy is ignored for one cycle (guard). The next tx_req comes no earlier than the cycle after tx_busy is observed low.
- If rx_valid and timeout expiry coincide, the byte wins and the counter reloads.
- busy rises the cycle after A5 is accepted. It falls the cycle after the last response byte's wait phase completes, or on timeout.

## Test plan

- Write OK: A5,01,03,5C,5E -> response 5A,00. A later read A5,02,03,01 -> response 5A,00,5C.
- ctrl write: A5,01,00,81,80 -> ctrl_out = 81 exactly one cycle after EXEC; response 5A,00.
- Bad checksum: A5,01,04,11,00 -> response 5A,01; register 4 remains 00. Same frame with rx_err high on the data byte -> response 5A,03.
- Read-only / unknown: A5,01,0F,22,2C -> 5A,04. A5,02,0F,0D with status_in=C3 -> 5A,00,C3. A5,07,02,05 -> 5A,02.
- Timeout: A5,01 then silence for TIMEOUT_CYCLES -> frame_drop pulse, busy low, no tx_req. Next a full valid frame is served normally.
- Backpressure: hold tx_busy high 50 cycles after each tx_req. Check tx_data stays stable and that no second tx_req occurs before tx_busy falls. Junk bytes 00,A5 sent during the response are dropped.
